// File: rtl/ascon_pack.sv
// ascon_pack: shared types and constants for the ASCON permutation datapath.
//   type_state : five 64-bit state words, index 0 = x0 ... index 4 = x4.
//   NB_ROUNDS  : number of rounds in the full p12 permutation.
//   rcon()     : 8-bit round constant for a 4-bit round index.
package ascon_pack;

    localparam int NB_ROUNDS = 12;

    typedef logic [4:0][63:0] type_state;

    // Upper nibble counts down from F while the lower nibble counts up.
    // Out-of-range indices 12..15 simply wrap modulo 4 bits.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [3:0] hi;
        hi = 4'hF - r;
        return {hi, r};
    endfunction

endpackage

// File: rtl/pc.sv
// pc: ASCON constant-addition layer (p_C), registered output.
//   XORs rcon(round_i) into the low byte of x2; x0, x1, x3, x4 pass through.
//   Ports:
//     clock_i  in   rising-edge clock
//     reset_i  in   asynchronous active-high reset
//     valid_i  in   Pc_in_i / round_i valid this cycle
//     Pc_in_i  in   type_state input
//     round_i  in   4-bit round index
//     Pc_out_o out  registered result (holds when valid_i = 0)
//     valid_o  out  one-cycle-latency valid
//     err_o    out  sticky illegal-round flag
//   Optional feature macro: PC_ROUND_CHECK_EN
//     defined   : round_i > 11 adds constant 0x00 and sets err_o until reset
//     undefined : constant formula applied to any round_i, err_o tied to 0
module pc
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       valid_i,
    input  type_state  Pc_in_i,
    input  logic [3:0] round_i,
    output type_state  Pc_out_o,
    output logic       valid_o,
    output logic       err_o
);

    logic [7:0] rc;
    logic       bad_round;
    type_state  pc_next;

    always_comb begin
        rc        = rcon(round_i);
        bad_round = 1'b0;
`ifdef PC_ROUND_CHECK_EN
        bad_round = (round_i > 4'(NB_ROUNDS - 1));
        if (bad_round) rc = 8'h00;
`endif
        pc_next       = Pc_in_i;
        pc_next[2]    = Pc_in_i[2] ^ {56'h0, rc};
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            Pc_out_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) Pc_out_o <= pc_next;
        end
    end

`ifdef PC_ROUND_CHECK_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)                   err_o <= 1'b0;
        else if (valid_i && bad_round) err_o <= 1'b1;
    end
`else
    assign err_o = 1'b0;
    logic unused_bad;
    assign unused_bad = bad_round;
`endif

endmodule

// File: tb/tb_pc.sv
module tb_pc;
    import ascon_pack::*;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    type_state  Pc_in_i;
    logic [3:0] round_i;
    type_state  Pc_out_o;
    logic       valid_o;
    logic       err_o;

    int errors = 0;
    int checks = 0;

    pc dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .Pc_in_i (Pc_in_i),
        .round_i (round_i),
        .Pc_out_o(Pc_out_o),
        .valid_o (valid_o),
        .err_o   (err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive at negedge, sample 1 time unit after the following posedge
    task automatic step(input logic v, input logic [3:0] r, input type_state s);
        @(negedge clock_i);
        valid_i = v;
        round_i = r;
        Pc_in_i = s;
        @(posedge clock_i);
        #1;
    endtask

    type_state  s0, zs, exp_st, last;
    logic [7:0] ctab [12];

    initial begin
        ctab = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
        s0[0] = 64'h00001000808C0001;
        s0[1] = 64'h6CB10AD9CA912F80;
        s0[2] = 64'h691AED630E81901F;
        s0[3] = 64'h0C4C36A20853217C;
        s0[4] = 64'h46487B3E06D9D7A8;
        zs    = '0;

        reset_i = 1'b1;
        valid_i = 1'b0;
        round_i = 4'd0;
        Pc_in_i = '0;
        #12;
        chk("reset_out",   Pc_out_o, '0);
        chk("reset_valid", {319'h0, valid_o}, 320'h0);
        chk("reset_err",   {319'h0, err_o},   320'h0);
        @(negedge clock_i);
        reset_i = 1'b0;

        // round 0 single transaction
        step(1'b1, 4'd0, s0);
        chk("r0_x2", {256'h0, Pc_out_o[2]}, {256'h0, 64'h691AED630E81901F ^ 64'hF0});
        exp_st = s0;
        exp_st[2] = 64'h691AED630E8190EF;
        chk("r0_state", Pc_out_o, exp_st);
        chk("r0_valid", {319'h0, valid_o}, 320'h1);

        // back-to-back sweep, reset pulsed before round 5
        for (int r = 0; r < 12; r++) begin
            if (r == 5) begin
                @(negedge clock_i);
                valid_i = 1'b0;
                reset_i = 1'b1;
                #1;
                chk("midrst_out",   Pc_out_o, '0);
                chk("midrst_valid", {319'h0, valid_o}, 320'h0);
                chk("midrst_err",   {319'h0, err_o},   320'h0);
                #2;
                reset_i = 1'b0;
            end
            step(1'b1, 4'(r), s0);
            exp_st = s0;
            exp_st[2][7:0] = 8'h1F ^ ctab[r];
            chk($sformatf("sweep_r%0d", r), Pc_out_o, exp_st);
            chk($sformatf("sweep_v%0d", r), {319'h0, valid_o}, 320'h1);
        end
        last = exp_st;

        // idle cycle: output holds, valid drops
        step(1'b0, 4'd3, zs);
        chk("hold_out",   Pc_out_o, last);
        chk("hold_valid", {319'h0, valid_o}, 320'h0);

        // out-of-range round on the all-zero state
        step(1'b1, 4'd12, zs);
`ifdef PC_ROUND_CHECK_EN
        chk("r12_out", Pc_out_o, '0);
        chk("r12_err", {319'h0, err_o}, 320'h1);
        chk("r12_valid", {319'h0, valid_o}, 320'h1);
        step(1'b1, 4'd0, zs);
        exp_st = '0;
        exp_st[2] = 64'hF0;
        chk("sticky_out", Pc_out_o, exp_st);
        chk("sticky_err", {319'h0, err_o}, 320'h1);
`else
        exp_st = '0;
        exp_st[2] = 64'h3C;
        chk("r12_out", Pc_out_o, exp_st);
        chk("r12_err", {319'h0, err_o}, 320'h0);
        chk("r12_valid", {319'h0, valid_o}, 320'h1);
        step(1'b1, 4'd15, zs);
        exp_st = '0;
        exp_st[2] = 64'h0F;
        chk("r15_out", Pc_out_o, exp_st);
        chk("r15_err", {319'h0, err_o}, 320'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
